// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the IF/LS memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  localparam logic [3:0] BMASK_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// ACCESS watchdog: counts ACCESS cycles without an ack and flags the cycle that reaches TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter holds the number of unacked ACCESS cycles already completed.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store
// with LS priority, an IF anti-starvation streak and an ACCESS timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_vld,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_bmask,
  output logic              ls_rsp_vld,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_bmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a requester raises req with stable fields and holds it until
  // its one-cycle rsp_vld; requests are only sampled in IDLE. mem_req is held
  // with stable fields until the cycle mem_ack is seen (or the timeout fires).

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_bmask_q, mem_bmask_d;
  logic              if_rsp_vld_q, if_rsp_vld_d;
  logic              ls_rsp_vld_q, ls_rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              grant_ls;
  logic              streak_full;
  logic [DATA_W-1:0] rsp_data;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;

  assign streak_full = (streak_q == 3'(STARVE_MAX));

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_bmask_d  = mem_bmask_q;
    if_rsp_vld_d = 1'b0;
    ls_rsp_vld_d = 1'b0;
    rsp_err_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    grant_ls     = 1'b0;
    rsp_data     = '0;
    tmr_clear    = 1'b0;
    tmr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          grant_ls  = ls_req && !(if_req && streak_full);
          state_d   = ACCESS;
          mem_req_d = 1'b1;
          tmr_clear = 1'b1;
          if (grant_ls) begin
            owner_d     = OWN_LS;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_bmask_d = ls_bmask;
            // Streak counts LS wins that kept a pending fetch waiting.
            if (!if_req) begin
              streak_d = '0;
            end else if (!streak_full) begin
              streak_d = streak_q + 3'd1;
            end
          end else begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_bmask_d = BMASK_FULL;
            streak_d    = '0;
          end
        end
      end
      ACCESS: begin
        tmr_en = !mem_ack;
        if (mem_ack || tmr_expired) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rsp_err_d = !mem_ack;
          rsp_data  = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          if (owner_q == OWN_IF) begin
            if_rsp_vld_d = 1'b1;
            if_rdata_d   = rsp_data;
          end else begin
            ls_rsp_vld_d = 1'b1;
            ls_rdata_d   = rsp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      streak_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_bmask_q  <= '0;
      if_rsp_vld_q <= 1'b0;
      ls_rsp_vld_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_bmask_q  <= mem_bmask_d;
      if_rsp_vld_q <= if_rsp_vld_d;
      ls_rsp_vld_q <= ls_rsp_vld_d;
      rsp_err_q    <= rsp_err_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign if_rsp_vld = if_rsp_vld_q;
  assign if_rdata   = if_rdata_q;
  assign ls_rsp_vld = ls_rsp_vld_q;
  assign ls_rdata   = ls_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_bmask  = mem_bmask_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scenarios drive requests, expected
// responses are queued at drive time and checked when rsp_vld appears.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_vld;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_bmask;
  logic              ls_rsp_vld;
  logic [DATA_W-1:0] ls_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Expected response: {is_ls, err, rdata}
  logic [33:0] exp_q[$];
  int pass_cnt;
  int total_cnt;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rsp_vld (if_rsp_vld),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_bmask   (ls_bmask),
    .ls_rsp_vld (ls_rsp_vld),
    .ls_rdata   (ls_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_bmask  (mem_bmask),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [33:0] rsp(input bit is_ls, input bit err, input logic [31:0] d);
    return {is_ls, err, d};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_rsp_vld, ls_rsp_vld, rsp_err, busy, mem_req, mem_we, mem_bmask}), 64'd0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, "_ls_rdata"}, 64'(ls_rdata), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Driver helpers (all run on the falling edge)
  task automatic wait_mem_req(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (mem_req) break;
    end
    check({tag, "_mem_req_seen"}, 64'(mem_req), 64'd1);
  endtask

  task automatic ack_now(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  // Scoreboard: pop the oldest expectation when a response is visible.
  task automatic expect_rsp(input string tag, input int max_wait);
    logic [33:0] exp_v;
    logic [33:0] obs_v;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i <= max_wait; i++) begin
      if (if_rsp_vld || ls_rsp_vld) begin
        seen = 1'b1;
        break;
      end
      if (i < max_wait) @(negedge clk);
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_one_vld"}, 64'(if_rsp_vld && ls_rsp_vld), 64'd0);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      obs_v = {ls_rsp_vld, rsp_err, (ls_rsp_vld ? ls_rdata : if_rdata)};
      check(tag, 64'(obs_v), 64'(exp_v));
    end
  endtask

  initial begin
    int n;
    int cnt;
    int drop;
    logic [31:0] d;

    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    ls_bmask  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: single fetch, zero-wait memory, minimum latency
    if_req  = 1'b1;
    if_addr = 32'h100;
    exp_q.push_back(rsp(1'b0, 1'b0, 32'hDEADBEEF));
    @(negedge clk);
    check("s1_mem_req", 64'(mem_req), 64'd1);
    check("s1_mem_addr", 64'(mem_addr), 64'h100);
    check("s1_mem_we_bmask", 64'({mem_we, mem_bmask}), 64'h0F);
    check("s1_busy", 64'(busy), 64'd1);
    ack_now(32'hDEADBEEF);
    expect_rsp("s1_rsp", 0);
    check("s1_mem_req_drop", 64'(mem_req), 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("s1_vld_pulse", 64'(if_rsp_vld), 64'd0);
    check("s1_rdata_hold", 64'(if_rdata), 64'hDEADBEEF);
    check("s1_idle", 64'(busy), 64'd0);

    // Scenario 2: simultaneous requests, LS store wins, IF follows
    if_req   = 1'b1;
    if_addr  = 32'h300;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h2000;
    ls_wdata = 32'h12345678;
    ls_bmask = 4'b0011;
    exp_q.push_back(rsp(1'b1, 1'b0, 32'h0));
    exp_q.push_back(rsp(1'b0, 1'b0, 32'hCAFEF00D));
    @(negedge clk);
    check("s2_ls_mem_req", 64'(mem_req), 64'd1);
    check("s2_ls_we", 64'(mem_we), 64'd1);
    check("s2_ls_addr", 64'(mem_addr), 64'h2000);
    check("s2_ls_wdata", 64'(mem_wdata), 64'h12345678);
    check("s2_ls_bmask", 64'(mem_bmask), 64'h3);
    ack_now(32'h55555555);
    expect_rsp("s2_ls_rsp", 0);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    wait_mem_req("s2_if", n);
    check("s2_if_next_idle", 64'(n), 64'd2);
    check("s2_if_addr", 64'(mem_addr), 64'h300);
    check("s2_if_we_bmask", 64'({mem_we, mem_bmask}), 64'h0F);
    ack_now(32'hCAFEF00D);
    expect_rsp("s2_if_rsp", 0);
    if_req = 1'b0;
    @(negedge clk);

    // Scenario 3: held fetch against a stream of loads -> 4 LS then IF
    if_req  = 1'b1;
    if_addr = 32'h400;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h500;
    mem_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_mem_req("s3_grant", n);
      check("s3_owner", 64'(mem_addr), (g < 4) ? 64'h500 : 64'h400);
      d = 32'hA000_0000 + 32'(g);
      mem_rdata = d;
      exp_q.push_back(rsp(g < 4, 1'b0, d));
      @(negedge clk);
      expect_rsp("s3_rsp", 0);
    end
    if_req  = 1'b0;
    ls_req  = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);

    // Scenario 4: no ack -> error response after 255 ACCESS cycles
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h600;
    exp_q.push_back(rsp(1'b1, 1'b1, 32'h0));
    wait_mem_req("s4", n);
    cnt  = 0;
    drop = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_rsp_vld || ls_rsp_vld) break;
      cnt++;
      if (!mem_req) drop++;
    end
    check("s4_access_cycles", 64'(cnt + 1), 64'd255);
    check("s4_mem_req_stable", 64'(drop), 64'd0);
    check("s4_mem_req_low", 64'(mem_req), 64'd0);
    expect_rsp("s4_rsp", 0);
    ls_req = 1'b0;
    @(negedge clk);
    check("s4_busy_low", 64'(busy), 64'd0);

    // Scenario 5: reset mid-ACCESS, stray ack, then normal service
    if_req  = 1'b1;
    if_addr = 32'h700;
    wait_mem_req("s5", n);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("s5_rst");
    rst_n   = 1'b1;
    if_req  = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s5_stray", 64'({if_rsp_vld, ls_rsp_vld, mem_req, busy}), 64'd0);
    end
    mem_ack = 1'b0;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h800;
    exp_q.push_back(rsp(1'b1, 1'b0, 32'h0BADF00D));
    wait_mem_req("s5_after", n);
    check("s5_after_addr", 64'(mem_addr), 64'h800);
    ack_now(32'h0BADF00D);
    expect_rsp("s5_rsp", 0);
    ls_req = 1'b0;
    @(negedge clk);

    // Scenario 6: ack in the cycle the counter reaches TIMEOUT
    if_req  = 1'b1;
    if_addr = 32'h900;
    exp_q.push_back(rsp(1'b0, 1'b0, 32'h600D600D));
    wait_mem_req("s6", n);
    repeat (254) @(negedge clk);
    check("s6_still_access", 64'({mem_req, if_rsp_vld}), 64'h2);
    ack_now(32'h600D600D);
    if_req = 1'b0;
    expect_rsp("s6_rsp", 0);
    @(negedge clk);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while fetch waits.
- TIMEOUT, 255, ACCESS cycles allowed before an error response.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset, synchronous and active-low.
- if_req, in, 1, fetch request; held until if_rsp_vld.
- if_addr, in, ADDR_W, fetch address.
- if_rsp_vld, out, 1, fetch response pulse.
- if_rdata, out, DATA_W, fetch read data.
- ls_req, in, 1, load/store request; held until ls_rsp_vld.
- ls_we, in, 1, store when 1.
- ls_addr, in, ADDR_W, load/store address.
- ls_wdata, in, DATA_W, store data.
- ls_bmask, in, 4, byte enables.
- ls_rsp_vld, out, 1, load/store response pulse.
- ls_rdata, out, DATA_W, load data.
- rsp_err, out, 1, timeout flag, qualified by either rsp_vld.
- mem_req, out, 1, memory request; held until mem_ack or timeout.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_bmask, out, 4, memory byte enables.
- mem_ack, in, 1, memory completion; mem_rdata valid the same cycle.
- mem_rdata, in, DATA_W, memory read data.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 The block SHALL share one single-port memory between instruction fetch (IF) and load/store (LS) using an FSM with states IDLE, ACCESS and RESP.
REQ-004 Request sampling SHALL occur only in IDLE; req lines are ignored in ACCESS and RESP.
REQ-005 In IDLE with at least one req high, the FSM SHALL latch the winner's addr, we, wdata and bmask and move to ACCESS.
- For IF grants: mem_we=0, mem_bmask=4'hF.
REQ-006 Arbitration SHALL be as follows.
- LS wins when both requesters are high.
- Exception: IF wins if streak==STARVE_MAX.
- Only one high: that requester wins.
REQ-007 The 3-bit streak counter SHALL update on each grant as follows.
- Increments on an LS grant made while if_req is high.
- Clears on any IF grant.
- Clears on an LS grant with if_req low.
- Saturates at STARVE_MAX.
REQ-008 In ACCESS, mem_req and all mem_* fields SHALL be driven from registers and held stable until exit.
REQ-009 On mem_ack in ACCESS, the FSM SHALL move to RESP and respond as follows.
- Next cycle: the granted rsp_vld is high for exactly one cycle.
- rdata = captured mem_rdata (0 for stores).
- rsp_err=0.
- mem_req drops in that same cycle.
REQ-010 A cycle counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ack.
- When it reaches TIMEOUT: go to RESP with rsp_err=1, rdata=0, mem_req=0.
- A mem_ack in the same cycle as the counter reaching TIMEOUT wins: normal response.
REQ-011 RESP SHALL last one cycle, then go to IDLE.
- A req still high in that IDLE cycle is a new request.
- Minimum req-to-rsp latency: 3 cycles (req seen at t, mem_req at t+1 with ack, rsp at t+2).
REQ-012 mem_ack outside ACCESS SHALL be ignored.
REQ-013 At most one rsp_vld SHALL be high in any cycle, and rsp_vld SHALL never be high outside RESP.
REQ-014 if_rdata and ls_rdata SHALL hold their last value when not valid.

Reset
REQ-015 While rst_n=0 at a clock edge, the block SHALL apply the following.
- State = IDLE; streak and timeout counters = 0.
- All outputs = 0, including rdata registers and latched fields.
REQ-016 Reset during ACCESS or RESP SHALL abandon the transaction: no rsp_vld is emitted for it, and a late mem_ack is ignored per REQ-012.

Structure
REQ-017 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the grant-owner enum (OWN_IF, OWN_LS) and default parameter constants.
REQ-018 The timeout counter SHALL be sub-module mem_arb_timer (clear, enable, expired outputs); all other logic stays in mem_arbiter.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Scenario 1: if_req=1, addr=0x100; memory acks in the first ACCESS cycle with 0xDEADBEEF -> if_rsp_vld exactly 3 cycles after req, if_rdata=0xDEADBEEF, rsp_err=0.
- Scenario 2: if_req and ls_req high together, ls_we=1, addr=0x2000, wdata=0x12345678, bmask=4'b0011 -> LS granted first with mem_we=1 and those exact fields; IF served in the next IDLE.
- Scenario 3: ls_req re-raised every IDLE while if_req is held, zero-wait memory -> four LS grants, then the fifth grant goes to IF.
- Scenario 4: mem_ack never asserted -> rsp_vld with rsp_err=1 and rdata=0 after 255 ACCESS cycles, mem_req low, busy low one cycle later.
- Scenario 5: rst_n pulsed low mid-ACCESS, then a stray mem_ack -> no rsp_vld, all outputs 0, next request served normally.
- Scenario 6: mem_ack in the same cycle the counter reaches TIMEOUT -> normal response with rsp_err=0.
